calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Control/sequencing block for the calculator.
- Accepts debounced key events (newkey pulse, 5-bit keycode), builds hex operands, and holds the accumulator with its sign.
- Issues one operation at a time to a shared multi-cycle arithmetic unit over a req/ack handshake.
- Drives the value/sign/ovw display outputs; sits between the keypad decoder and the ALU datapath.

Parameters:
- DATA_W, 16, operand/accumulator magnitude width; must be a multiple of 4.
- ALU_TIMEOUT, 64, maximum cycles in WAIT before the op is abandoned as overflow.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- newkey  in  1  one-cycle pulse; keycode valid in that cycle
- keycode  in  5  bit4=1: hex digit in [3:0]; bit4=0: command A=add, 2=mult, 3=sub, 4=equals, 1=backspace; others ignored
- key_ready  out  1  1 when a key will be accepted (not in REQ/WAIT)
- alu_req  out  1  operation request, held until ack
- alu_op  out  2  00 add, 01 sub, 10 mult
- alu_a  out  DATA_W  accumulator magnitude
- alu_a_sign  out  1  accumulator sign (1=negative)
- alu_b  out  DATA_W  second operand (non-negative)
- alu_ack  in  1  one-cycle; result fields valid this cycle
- alu_result  in  DATA_W  result magnitude
- alu_rsign  in  1  result sign
- alu_ovw  in  1  result exceeds DATA_W magnitude
- value  out  DATA_W  displayed magnitude
- sign  out  1  displayed sign
- ovw  out  1  sticky overflow flag

Behaviour:
- States: ENTER_A, ENTER_B, REQ, WAIT, SHOW. Reset gives ENTER_A and clears entry, acc, acc_sign, pend_op, b_dig, ovw and the timeout counter. Reset outputs: value=0, sign=0, ovw=0, alu_req=0, alu_op=00, alu_a=0, alu_b=0, key_ready=1.
- Keys are sampled only when newkey=1 on a clock edge. Keys arriving in REQ/WAIT are dropped with no side effect; this includes newkey coinciding with alu_ack.
- Digit, ENTER_A/ENTER_B:
  - If entry[DATA_W-1:DATA_W-4]!=0 the digit is ignored (operand full).
  - Otherwise entry <= {entry[DATA_W-5:0], d}.
  - In ENTER_B, b_dig <= 1.
- Digit, SHOW: entry <= d, acc_sign <= 0, go to ENTER_A. This starts a new calculation; ovw is not cleared.
- Backspace: entry <= entry >> 4 in ENTER_A/ENTER_B. Ignored in SHOW.
- Operator, ENTER_A: acc <= entry, acc_sign <= 0, entry <= 0, b_dig <= 0, pend_op latched, go to ENTER_B.
- Operator, SHOW: acc and acc_sign retained (chaining), entry <= 0, b_dig <= 0, pend_op latched, go to ENTER_B.
- Operator, ENTER_B: only replaces pend_op; no computation, entry unchanged.
- Equals, ENTER_B: go to REQ. An empty entry acts as operand 0.
- Equals, ENTER_A/SHOW: ignored.
- REQ is one cycle after the equals edge:
  - alu_req=1 with alu_op=pend_op, alu_a=acc, alu_a_sign=acc_sign, alu_b=entry.
  - Go to WAIT; alu_req and the operand outputs stay stable until the ack cycle.
- WAIT, alu_ack=1:
  - alu_req drops the next cycle.
  - If alu_ovw=1: acc <= 0, acc_sign <= 0, ovw <= 1.
  - Else: acc <= alu_result, acc_sign <= alu_rsign; a zero result forces sign 0.
  - Go to SHOW.
- ALU timeout: a counter starts on entering REQ. If no ack has arrived ALU_TIMEOUT cycles after alu_req rose:
  - Treat as overflow: acc=0, acc_sign=0, ovw=1.
  - Go to SHOW; alu_req drops.
  - A late ack is then ignored.
- ovw is sticky until reset; calculation continues on acc=0 after overflow.
- Display (registered, updates the cycle after the causing edge):
  - ENTER_A: value=entry, sign=0.
  - ENTER_B with b_dig=0: value=acc, sign=acc_sign.
  - ENTER_B with b_dig=1: value=entry, sign=0.
  - REQ/WAIT: previous display held.
  - SHOW: value=acc, sign=acc_sign.
- Latency:
  - equals edge -> alu_req high 1 cycle later;
  - ack edge -> value/sign/ovw updated 1 cycle later;
  - key_ready low from REQ entry until the SHOW cycle.
- Reset asserted mid-operation: alu_req and all outputs clear immediately (async); any in-flight ack is ignored.

Test Plan:
- Keys 1,2,3,4, add, 0,0,1,1, equals; ALU acks after 5 cycles with 0x1245/sign 0 -> alu_op=00, alu_a=0x1234, alu_b=0x0011 held stable until ack; value=0x1245, sign=0, ovw=0.
- 5, sub, 9, equals; ALU returns 4/sign 1 -> sign=1, value=0x0004. Then sub, 2, equals -> alu_a=4, alu_a_sign=1, alu_b=2, alu_op=01 (chaining).
- Digits 1,2,3,4,5 -> value=0x1234 (5 ignored). Backspace -> 0x0123. Add then mult before any digit -> pend_op=mult, value shows acc=0x0123.
- FFFF mult 2 equals; ALU alu_ovw=1 -> value=0, sign=0, ovw=1. Following 1 add 1 equals with ack 2 -> value=2, ovw stays 1.
- Equals with no ack for ALU_TIMEOUT cycles -> ovw=1, value=0, state SHOW. Late ack ignored; key pressed during WAIT dropped (key_ready=0).
- reset=0 asserted while alu_req=1 -> alu_req=0 and value/sign/ovw=0 without a clock edge. Release, then 7 -> value=7.

Source files
------------

// File: rtl/calc_sequencer.sv
// Calculator control sequencer: key entry, accumulator, ALU handshake and display.
module calc_sequencer #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned ALU_TIMEOUT = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              newkey,
    input  logic [4:0]        keycode,
    output logic              key_ready,
    output logic              alu_req,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic              alu_a_sign,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_ack,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_rsign,
    input  logic              alu_ovw,
    output logic [DATA_W-1:0] value,
    output logic              sign,
    output logic              ovw
);

    localparam int unsigned CNT_W = $clog2(ALU_TIMEOUT + 1);

    localparam logic [2:0] S_ENTER_A = 3'd0;
    localparam logic [2:0] S_ENTER_B = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_WAIT    = 3'd3;
    localparam logic [2:0] S_SHOW    = 3'd4;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MULT = 2'b10;

    localparam logic [3:0] KEY_BS   = 4'h1;
    localparam logic [3:0] KEY_MULT = 4'h2;
    localparam logic [3:0] KEY_SUB  = 4'h3;
    localparam logic [3:0] KEY_EQ   = 4'h4;
    localparam logic [3:0] KEY_ADD  = 4'hA;

    // Internal state
    logic [2:0]        state, state_nxt;
    logic [DATA_W-1:0] entry, entry_nxt;
    logic [DATA_W-1:0] acc, acc_nxt;
    logic              acc_sign, acc_sign_nxt;
    logic [1:0]        pend_op, pend_op_nxt;
    logic              b_dig, b_dig_nxt;
    logic              ovw_nxt;
    logic [CNT_W-1:0]  tmo_cnt, tmo_cnt_nxt;

    // Registered output next values
    logic              key_ready_nxt;
    logic              alu_req_nxt;
    logic [1:0]        alu_op_nxt;
    logic [DATA_W-1:0] alu_a_nxt;
    logic              alu_a_sign_nxt;
    logic [DATA_W-1:0] alu_b_nxt;
    logic [DATA_W-1:0] value_nxt;
    logic              sign_nxt;

    // Key decode
    logic       key_digit_c;
    logic       key_bs_c;
    logic       key_eq_c;
    logic       key_op_c;
    logic [1:0] key_opcode_c;
    logic       entry_full_c;
    logic       busy_nxt_c;

    // Classify the incoming key event
    always_comb begin
        key_digit_c  = newkey && keycode[4];
        key_bs_c     = newkey && !keycode[4] && (keycode[3:0] == KEY_BS);
        key_eq_c     = newkey && !keycode[4] && (keycode[3:0] == KEY_EQ);
        key_op_c     = newkey && !keycode[4] &&
                       ((keycode[3:0] == KEY_ADD) || (keycode[3:0] == KEY_SUB) ||
                        (keycode[3:0] == KEY_MULT));
        key_opcode_c = OP_ADD;
        if (keycode[3:0] == KEY_SUB) begin
            key_opcode_c = OP_SUB;
        end else if (keycode[3:0] == KEY_MULT) begin
            key_opcode_c = OP_MULT;
        end
        entry_full_c = (entry[DATA_W-1 -: 4] != 4'd0);
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        entry_nxt    = entry;
        acc_nxt      = acc;
        acc_sign_nxt = acc_sign;
        pend_op_nxt  = pend_op;
        b_dig_nxt    = b_dig;
        ovw_nxt      = ovw;
        tmo_cnt_nxt  = tmo_cnt;

        key_ready_nxt  = key_ready;
        alu_req_nxt    = alu_req;
        alu_op_nxt     = alu_op;
        alu_a_nxt      = alu_a;
        alu_a_sign_nxt = alu_a_sign;
        alu_b_nxt      = alu_b;
        value_nxt      = value;
        sign_nxt       = sign;
        busy_nxt_c     = 1'b0;

        case (state)
            S_ENTER_A: begin
                if (key_digit_c) begin
                    if (!entry_full_c) begin
                        entry_nxt = {entry[DATA_W-5:0], keycode[3:0]};
                    end
                end else if (key_bs_c) begin
                    entry_nxt = entry >> 4;
                end else if (key_op_c) begin
                    acc_nxt      = entry;
                    acc_sign_nxt = 1'b0;
                    entry_nxt    = '0;
                    b_dig_nxt    = 1'b0;
                    pend_op_nxt  = key_opcode_c;
                    state_nxt    = S_ENTER_B;
                end
            end
            S_ENTER_B: begin
                if (key_digit_c) begin
                    if (!entry_full_c) begin
                        entry_nxt = {entry[DATA_W-5:0], keycode[3:0]};
                    end
                    b_dig_nxt = 1'b1;
                end else if (key_bs_c) begin
                    entry_nxt = entry >> 4;
                end else if (key_op_c) begin
                    pend_op_nxt = key_opcode_c;
                end else if (key_eq_c) begin
                    tmo_cnt_nxt = '0;
                    state_nxt   = S_REQ;
                end
            end
            S_REQ, S_WAIT: begin
                if ((state == S_WAIT) && alu_ack) begin
                    if (alu_ovw) begin
                        acc_nxt      = '0;
                        acc_sign_nxt = 1'b0;
                        ovw_nxt      = 1'b1;
                    end else begin
                        acc_nxt      = alu_result;
                        acc_sign_nxt = alu_rsign && (alu_result != '0);
                    end
                    state_nxt = S_SHOW;
                end else if (tmo_cnt == CNT_W'(ALU_TIMEOUT - 1)) begin
                    acc_nxt      = '0;
                    acc_sign_nxt = 1'b0;
                    ovw_nxt      = 1'b1;
                    state_nxt    = S_SHOW;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
                    state_nxt   = S_WAIT;
                end
            end
            S_SHOW: begin
                if (key_digit_c) begin
                    entry_nxt    = DATA_W'(keycode[3:0]);
                    acc_sign_nxt = 1'b0;
                    state_nxt    = S_ENTER_A;
                end else if (key_op_c) begin
                    entry_nxt   = '0;
                    b_dig_nxt   = 1'b0;
                    pend_op_nxt = key_opcode_c;
                    state_nxt   = S_ENTER_B;
                end
            end
            default: begin
                state_nxt = S_ENTER_A;
            end
        endcase

        busy_nxt_c    = (state_nxt == S_REQ) || (state_nxt == S_WAIT);
        alu_req_nxt   = busy_nxt_c;
        key_ready_nxt = !busy_nxt_c;

        if ((state_nxt == S_REQ) && (state != S_REQ)) begin
            alu_op_nxt     = pend_op_nxt;
            alu_a_nxt      = acc_nxt;
            alu_a_sign_nxt = acc_sign_nxt;
            alu_b_nxt      = entry_nxt;
        end

        case (state_nxt)
            S_ENTER_A: begin
                value_nxt = entry_nxt;
                sign_nxt  = 1'b0;
            end
            S_ENTER_B: begin
                if (b_dig_nxt) begin
                    value_nxt = entry_nxt;
                    sign_nxt  = 1'b0;
                end else begin
                    value_nxt = acc_nxt;
                    sign_nxt  = acc_sign_nxt;
                end
            end
            S_SHOW: begin
                value_nxt = acc_nxt;
                sign_nxt  = acc_sign_nxt;
            end
            default: begin
                value_nxt = value;
                sign_nxt  = sign;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_ENTER_A;
            entry      <= '0;
            acc        <= '0;
            acc_sign   <= 1'b0;
            pend_op    <= OP_ADD;
            b_dig      <= 1'b0;
            ovw        <= 1'b0;
            tmo_cnt    <= '0;
            key_ready  <= 1'b1;
            alu_req    <= 1'b0;
            alu_op     <= OP_ADD;
            alu_a      <= '0;
            alu_a_sign <= 1'b0;
            alu_b      <= '0;
            value      <= '0;
            sign       <= 1'b0;
        end else begin
            state      <= state_nxt;
            entry      <= entry_nxt;
            acc        <= acc_nxt;
            acc_sign   <= acc_sign_nxt;
            pend_op    <= pend_op_nxt;
            b_dig      <= b_dig_nxt;
            ovw        <= ovw_nxt;
            tmo_cnt    <= tmo_cnt_nxt;
            key_ready  <= key_ready_nxt;
            alu_req    <= alu_req_nxt;
            alu_op     <= alu_op_nxt;
            alu_a      <= alu_a_nxt;
            alu_a_sign <= alu_a_sign_nxt;
            alu_b      <= alu_b_nxt;
            value      <= value_nxt;
            sign       <= sign_nxt;
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer.
module tb_calc_sequencer;

    logic        clock;
    logic        reset;
    logic        newkey;
    logic [4:0]  keycode;
    logic        key_ready;
    logic        alu_req;
    logic [1:0]  alu_op;
    logic [15:0] alu_a;
    logic        alu_a_sign;
    logic [15:0] alu_b;
    logic        alu_ack;
    logic [15:0] alu_result;
    logic        alu_rsign;
    logic        alu_ovw;
    logic [15:0] value;
    logic        sign;
    logic        ovw;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [4:0] K_BS   = 5'h01;
    localparam logic [4:0] K_MULT = 5'h02;
    localparam logic [4:0] K_SUB  = 5'h03;
    localparam logic [4:0] K_EQ   = 5'h04;
    localparam logic [4:0] K_ADD  = 5'h0A;

    calc_sequencer #(.DATA_W(16), .ALU_TIMEOUT(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .newkey     (newkey),
        .keycode    (keycode),
        .key_ready  (key_ready),
        .alu_req    (alu_req),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_a_sign (alu_a_sign),
        .alu_b      (alu_b),
        .alu_ack    (alu_ack),
        .alu_result (alu_result),
        .alu_rsign  (alu_rsign),
        .alu_ovw    (alu_ovw),
        .value      (value),
        .sign       (sign),
        .ovw        (ovw)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [4:0] k);
        @(negedge clock);
        newkey  = 1'b1;
        keycode = k;
        @(negedge clock);
        newkey  = 1'b0;
        keycode = 5'h00;
    endtask

    task automatic dig(input logic [3:0] d);
        press({1'b1, d});
    endtask

    task automatic ack(input logic [15:0] res, input logic rs, input logic ov);
        @(negedge clock);
        alu_ack    = 1'b1;
        alu_result = res;
        alu_rsign  = rs;
        alu_ovw    = ov;
        @(negedge clock);
        alu_ack    = 1'b0;
        alu_result = 16'h0;
        alu_rsign  = 1'b0;
        alu_ovw    = 1'b0;
    endtask

    initial begin
        int cycles;
        bit found;

        reset = 1'b0; newkey = 1'b0; keycode = 5'h00;
        alu_ack = 1'b0; alu_result = 16'h0; alu_rsign = 1'b0; alu_ovw = 1'b0;

        // Reset state
        #12;
        chk("rst_value", 32'(value), 32'h0);
        chk("rst_sign", 32'(sign), 32'h0);
        chk("rst_ovw", 32'(ovw), 32'h0);
        chk("rst_req", 32'(alu_req), 32'h0);
        chk("rst_op", 32'(alu_op), 32'h0);
        chk("rst_a", 32'(alu_a), 32'h0);
        chk("rst_b", 32'(alu_b), 32'h0);
        chk("rst_ready", 32'(key_ready), 32'h1);
        @(negedge clock);
        reset = 1'b1;

        // 1234 + 0011
        dig(4'h1); dig(4'h2); dig(4'h3); dig(4'h4);
        chk("t1_entry_a", 32'(value), 32'h1234);
        press(K_ADD);
        chk("t1_show_acc", 32'(value), 32'h1234);
        dig(4'h0); dig(4'h0); dig(4'h1); dig(4'h1);
        chk("t1_entry_b", 32'(value), 32'h0011);
        press(K_EQ);
        chk("t1_req", 32'(alu_req), 32'h1);
        chk("t1_op", 32'(alu_op), 32'h0);
        chk("t1_a", 32'(alu_a), 32'h1234);
        chk("t1_a_sign", 32'(alu_a_sign), 32'h0);
        chk("t1_b", 32'(alu_b), 32'h0011);
        chk("t1_ready_lo", 32'(key_ready), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("t1_req_hold", 32'(alu_req), 32'h1);
            chk("t1_a_hold", 32'(alu_a), 32'h1234);
            chk("t1_b_hold", 32'(alu_b), 32'h0011);
        end
        ack(16'h1245, 1'b0, 1'b0);
        chk("t1_value", 32'(value), 32'h1245);
        chk("t1_sign", 32'(sign), 32'h0);
        chk("t1_ovw", 32'(ovw), 32'h0);
        chk("t1_req_drop", 32'(alu_req), 32'h0);
        chk("t1_ready_hi", 32'(key_ready), 32'h1);

        // 5 - 9 = -4, then chain - 2
        dig(4'h5);
        chk("t2_new_calc", 32'(value), 32'h0005);
        press(K_SUB);
        dig(4'h9);
        press(K_EQ);
        chk("t2_op", 32'(alu_op), 32'h1);
        chk("t2_a", 32'(alu_a), 32'h0005);
        chk("t2_b", 32'(alu_b), 32'h0009);
        ack(16'h0004, 1'b1, 1'b0);
        chk("t2_value", 32'(value), 32'h0004);
        chk("t2_sign", 32'(sign), 32'h1);
        press(K_SUB);
        chk("t2_chain_val", 32'(value), 32'h0004);
        chk("t2_chain_sign", 32'(sign), 32'h1);
        dig(4'h2);
        chk("t2_chain_b_sign", 32'(sign), 32'h0);
        press(K_EQ);
        chk("t2c_op", 32'(alu_op), 32'h1);
        chk("t2c_a", 32'(alu_a), 32'h0004);
        chk("t2c_a_sign", 32'(alu_a_sign), 32'h1);
        chk("t2c_b", 32'(alu_b), 32'h0002);
        ack(16'h0006, 1'b1, 1'b0);
        chk("t2c_value", 32'(value), 32'h0006);
        chk("t2c_sign", 32'(sign), 32'h1);

        // Operand full, backspace, operator replacement
        dig(4'h1); dig(4'h2); dig(4'h3); dig(4'h4); dig(4'h5);
        chk("t3_full", 32'(value), 32'h1234);
        press(K_BS);
        chk("t3_bs", 32'(value), 32'h0123);
        press(K_ADD);
        press(K_MULT);
        chk("t3_acc_disp", 32'(value), 32'h0123);
        dig(4'h3);
        press(K_EQ);
        chk("t3_op_mult", 32'(alu_op), 32'h2);
        chk("t3_a", 32'(alu_a), 32'h0123);
        chk("t3_b", 32'(alu_b), 32'h0003);
        ack(16'h0369, 1'b0, 1'b0);
        chk("t3_value", 32'(value), 32'h0369);

        // Overflow from ALU, then continue with sticky ovw
        dig(4'hF); dig(4'hF); dig(4'hF); dig(4'hF);
        press(K_MULT);
        dig(4'h2);
        press(K_EQ);
        chk("t4_a", 32'(alu_a), 32'hFFFF);
        ack(16'hFFFE, 1'b0, 1'b1);
        chk("t4_value", 32'(value), 32'h0);
        chk("t4_sign", 32'(sign), 32'h0);
        chk("t4_ovw", 32'(ovw), 32'h1);
        dig(4'h1);
        press(K_ADD);
        dig(4'h1);
        press(K_EQ);
        chk("t4_a2", 32'(alu_a), 32'h0001);
        chk("t4_b2", 32'(alu_b), 32'h0001);
        ack(16'h0002, 1'b0, 1'b0);
        chk("t4_value2", 32'(value), 32'h0002);
        chk("t4_ovw_sticky", 32'(ovw), 32'h1);

        // ALU timeout, key dropped during WAIT, late ack ignored
        press(K_EQ);
        chk("t5_eq_in_show", 32'(alu_req), 32'h0);
        press(K_ADD);
        press(K_EQ);
        chk("t5_req", 32'(alu_req), 32'h1);
        dig(4'h7);
        chk("t5_ready_lo", 32'(key_ready), 32'h0);
        chk("t5_key_dropped", 32'(value), 32'h0002);
        cycles = 2;
        found  = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clock);
            cycles++;
            if (!alu_req) found = 1'b1;
        end
        chk("t5_tmo_cycles", 32'(cycles), 32'd64);
        chk("t5_value", 32'(value), 32'h0);
        chk("t5_ovw", 32'(ovw), 32'h1);
        chk("t5_ready_hi", 32'(key_ready), 32'h1);
        ack(16'h0055, 1'b1, 1'b0);
        chk("t5_late_val", 32'(value), 32'h0);
        chk("t5_late_sign", 32'(sign), 32'h0);
        dig(4'h7);
        chk("t5_next_digit", 32'(value), 32'h0007);

        // Async reset while a request is outstanding
        press(K_ADD);
        dig(4'h1);
        press(K_EQ);
        chk("t6_req", 32'(alu_req), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_req_clr", 32'(alu_req), 32'h0);
        chk("t6_value_clr", 32'(value), 32'h0);
        chk("t6_sign_clr", 32'(sign), 32'h0);
        chk("t6_ovw_clr", 32'(ovw), 32'h0);
        chk("t6_ready", 32'(key_ready), 32'h1);
        @(negedge clock);
        reset = 1'b1;
        dig(4'h7);
        chk("t6_after", 32'(value), 32'h0007);
        chk("t6_ovw_after", 32'(ovw), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
